pic_isr_seq: RTL and testbench

In-service register and INTA sequencer for the 8259-style PIC. It sits directly downstream of the priority resolver and consumes that stage's "request outranks in-service" flag and winning level. It raises INT to the CPU, runs the two-pulse 8086 INTA cycle, sets and clears in-service bits, and drives the interrupt vector. It handles EOI commands and maintains the rotating priority base that feeds back into the resolver.

---
 rtl/pic_isr_seq.sv | 102 ++++++++++
 tb/tb_pic_isr_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pic_isr_seq.sv
// pic_isr_seq: 8259-style in-service register, INTA sequencer and EOI/priority-rotation handler.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   int_req, int_lvl     - resolver request flag and winning IR level
//   inta_n               - synchronised active-low CPU interrupt acknowledge
//   eoi_cmd, eoi_type    - EOI strobe and type (00 NS, 01 S, 10 rotate NS, 11 rotate S)
//   eoi_lvl              - level for specific EOI types
//   aeoi                 - automatic-EOI mode
//   vec_base             - vector bits T7..T3
//   int_out              - INT to the CPU
//   isr                  - in-service register
//   irr_clr              - one-cycle one-hot IRR clear pulse
//   prio_base            - lowest-priority level
//   vec_out, vec_oe      - vector byte and its drive enable
// Macro PIC_ISR_SEQ_ROTATE_EN enables rotating priority; otherwise prio_base stays 7.
module pic_isr_seq #(
   parameter int VEC_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             int_req,
   input  logic [2:0]       int_lvl,
   input  logic             inta_n,
   input  logic             eoi_cmd,
   input  logic [1:0]       eoi_type,
   input  logic [2:0]       eoi_lvl,
   input  logic             aeoi,
   input  logic [4:0]       vec_base,
   output logic             int_out,
   output logic [7:0]       isr,
   output logic [7:0]       irr_clr,
   output logic [2:0]       prio_base,
   output logic [VEC_W-1:0] vec_out,
   output logic             vec_oe
);
   typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;
   state_t state;
   logic inta_q, fall, rise, spur, spec;
   logic [2:0] lvl, ns_lvl, prio_nx;
   logic [7:0] set, eoi_clr, aeoi_clr;
   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;
   assign spec = eoi_type[0];
   // Later iterations win, so the lowest offset from prio_base+1 (highest priority) is kept.
   always_comb begin
      ns_lvl = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (isr[3'(prio_base + 3'd1 + 3'(i))]) ns_lvl = 3'(prio_base + 3'd1 + 3'(i));
   end
   assign set      = (state == REQ && fall && int_req) ? 8'h1 << int_lvl : 8'h0;
   assign eoi_clr  = !eoi_cmd ? 8'h0 : spec ? 8'h1 << eoi_lvl : (|isr) ? 8'h1 << ns_lvl : 8'h0;
   assign aeoi_clr = (state == ACK2 && rise && aeoi && !spur) ? 8'h1 << lvl : 8'h0;
`ifdef PIC_ISR_SEQ_ROTATE_EN
   assign prio_nx = !(eoi_cmd && eoi_type[1]) ? prio_base : spec ? eoi_lvl : (|isr) ? ns_lvl : prio_base;
`else
   logic unused_rot;
   assign unused_rot = eoi_type[1];
   assign prio_nx = 3'd7;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         inta_q    <= 1'b1;
         lvl       <= 3'd0;
         spur      <= 1'b0;
         int_out   <= 1'b0;
         isr       <= 8'h0;
         irr_clr   <= 8'h0;
         prio_base <= 3'd7;
         vec_out   <= '0;
         vec_oe    <= 1'b0;
      end else begin
         inta_q    <= inta_n;
         isr       <= (isr & ~(eoi_clr | aeoi_clr)) | set;
         irr_clr   <= set;
         prio_base <= prio_nx;
         case (state)
            IDLE: if (int_req) begin
               state   <= REQ;
               int_out <= 1'b1;
            end
            REQ: if (fall) begin
               lvl     <= int_req ? int_lvl : 3'd7;
               spur    <= ~int_req;
               int_out <= 1'b0;
               state   <= ACK1;
            end
            ACK1: if (rise) state <= WAIT2;
            WAIT2: if (fall) begin
               vec_out <= {vec_base, lvl};
               vec_oe  <= 1'b1;
               state   <= ACK2;
            end
            ACK2: if (rise) begin
               vec_oe <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pic_isr_seq.sv
// tb_pic_isr_seq: directed scoreboard bench for pic_isr_seq.
module tb_pic_isr_seq;
   logic clk = 1'b0, rst = 1'b1, int_req = 1'b0, inta_n = 1'b1, eoi_cmd = 1'b0, aeoi = 1'b0;
   logic [2:0] int_lvl = 3'd0, eoi_lvl = 3'd0;
   logic [1:0] eoi_type = 2'd0;
   logic [4:0] vec_base = 5'b01000;
   logic int_out, vec_oe;
   logic [7:0] isr, irr_clr, vec_out;
   logic [2:0] prio_base;
   int errors = 0, checks = 0;
   typedef struct {string tag; int id; logic [7:0] val;} exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   pic_isr_seq dut (
      .clk(clk), .rst(rst), .int_req(int_req), .int_lvl(int_lvl), .inta_n(inta_n),
      .eoi_cmd(eoi_cmd), .eoi_type(eoi_type), .eoi_lvl(eoi_lvl), .aeoi(aeoi), .vec_base(vec_base),
      .int_out(int_out), .isr(isr), .irr_clr(irr_clr), .prio_base(prio_base),
      .vec_out(vec_out), .vec_oe(vec_oe)
   );
   function automatic logic [7:0] obs(int id);
      case (id)
         0: return {7'd0, int_out};
         1: return isr;
         2: return irr_clr;
         3: return {5'd0, prio_base};
         4: return vec_out;
         default: return {7'd0, vec_oe};
      endcase
   endfunction
   task automatic push(string tag, int id, logic [7:0] val);
      exp_t e;
      e.tag = tag; e.id = id; e.val = val;
      sb.push_back(e);
   endtask
   task automatic check();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (obs(e.id) === e.val) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs(e.id), e.val);
         end
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push_reset(string tag);
      push({tag, "_int_out"}, 0, 8'h00);
      push({tag, "_isr"}, 1, 8'h00);
      push({tag, "_irr_clr"}, 2, 8'h00);
      push({tag, "_prio"}, 3, 8'h07);
      push({tag, "_vec_out"}, 4, 8'h00);
      push({tag, "_vec_oe"}, 5, 8'h00);
   endtask
   task automatic request(string tag, logic [2:0] l);
      int_req = 1'b1; int_lvl = l;
      tick();
      push({tag, "_int_out"}, 0, 8'h01);
      check();
   endtask
   task automatic ack(string tag, logic [7:0] isr1, logic [7:0] clr1, logic [7:0] vec, logic [7:0] isr_end);
      inta_n = 1'b0;
      tick();
      push({tag, "_int_out_low"}, 0, 8'h00);
      push({tag, "_isr_set"}, 1, isr1);
      push({tag, "_irr_clr"}, 2, clr1);
      check();
      int_req = 1'b0;
      tick();
      push({tag, "_irr_clr_1cyc"}, 2, 8'h00);
      check();
      inta_n = 1'b1;
      tick();
      inta_n = 1'b0;
      tick();
      push({tag, "_vec_out"}, 4, vec);
      push({tag, "_vec_oe"}, 5, 8'h01);
      check();
      inta_n = 1'b1;
      tick();
      push({tag, "_vec_oe_off"}, 5, 8'h00);
      push({tag, "_isr_end"}, 1, isr_end);
      check();
   endtask
   task automatic eoi(string tag, logic [1:0] t, logic [2:0] l, logic [7:0] isr_exp, logic [2:0] prio_exp);
      eoi_cmd = 1'b1; eoi_type = t; eoi_lvl = l;
      tick();
      eoi_cmd = 1'b0;
      push({tag, "_isr"}, 1, isr_exp);
      push({tag, "_prio"}, 3, {5'd0, prio_exp});
      check();
   endtask
   initial begin
      logic [2:0] rot_nsp, rot_sp;
`ifdef PIC_ISR_SEQ_ROTATE_EN
      rot_nsp = 3'd2; rot_sp = 3'd4;
`else
      rot_nsp = 3'd7; rot_sp = 3'd7;
`endif
      tick(); tick();
      push_reset("reset");
      check();
      rst = 1'b0;
      request("basic", 3'd3);
      ack("basic", 8'h08, 8'h08, 8'h43, 8'h08);
      eoi("spec_eoi", 2'b01, 3'd3, 8'h00, 3'd7);
      aeoi = 1'b1;
      request("aeoi", 3'd3);
      ack("aeoi", 8'h08, 8'h08, 8'h43, 8'h00);
      aeoi = 1'b0;
      request("lvl2", 3'd2);
      ack("lvl2", 8'h04, 8'h04, 8'h42, 8'h04);
      request("lvl5", 3'd5);
      ack("lvl5", 8'h24, 8'h20, 8'h45, 8'h24);
      eoi("ns_eoi", 2'b00, 3'd0, 8'h20, 3'd7);
      eoi("ns_eoi2", 2'b00, 3'd0, 8'h00, 3'd7);
      eoi("ns_eoi_empty", 2'b00, 3'd0, 8'h00, 3'd7);
      request("r2", 3'd2);
      ack("r2", 8'h04, 8'h04, 8'h42, 8'h04);
      request("r5", 3'd5);
      ack("r5", 8'h24, 8'h20, 8'h45, 8'h24);
      eoi("rot_ns", 2'b10, 3'd0, 8'h20, rot_nsp);
      eoi("ns_after_rot", 2'b00, 3'd0, 8'h00, rot_nsp);
      eoi("rot_sp", 2'b11, 3'd4, 8'h00, rot_sp);
      vec_base = 5'b10101;
      request("spur", 3'd6);
      int_req = 1'b0;
      tick();
      push("spur_int_held", 0, 8'h01);
      check();
      ack("spur", 8'h00, 8'h00, 8'hAF, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vec_base = 5'b01000;
      request("pre_rst", 3'd0);
      inta_n = 1'b0;
      tick();
      push("pre_rst_isr", 1, 8'h01);
      check();
      int_req = 1'b0;
      inta_n = 1'b1;
      tick();
      inta_n = 1'b0;
      rst = 1'b1;
      tick();
      push_reset("rst_wait2");
      check();
      rst = 1'b0;
      tick();
      push("post_rst_idle", 0, 8'h00);
      check();
      request("restart", 3'd1);
      tick();
      push("held_inta_isr", 1, 8'h00);
      push("held_inta_clr", 2, 8'h00);
      check();
      inta_n = 1'b1;
      tick();
      ack("restart", 8'h02, 8'h02, 8'h41, 8'h02);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
